input_vc_buffer: RTL

//  - Per-port input buffer of the router; five instances (N/E/S/W/Local) feed the crossbar switch data/valid/vc inputs.
//  - Stores incoming flits in one FIFO per virtual channel (VC).
//  - Presents one head flit per cycle, chosen round-robin among non-empty VCs.
//  - Returns one credit per dequeued flit to the upstream router.

---
 rtl/noc_pkg.sv | 35 +++
 rtl/vc_fifo.sv | 55 +++++
 rtl/input_vc_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: widths, port select codes and flit fields.
// Imported by the input buffer and its per-VC FIFO.
package noc_pkg;

  localparam int FLIT_W   = 64;
  localparam int VC_W     = 2;
  localparam int NUM_VC   = 4;
  localparam int VC_DEPTH = 4;

  typedef enum logic [2:0] {
    PORT_N    = 3'b000,
    PORT_E    = 3'b001,
    PORT_S    = 3'b010,
    PORT_W    = 3'b011,
    PORT_L    = 3'b100,
    PORT_NONE = 3'b111
  } port_sel_e;

  localparam int FLIT_TYPE_MSB = FLIT_W - 1;
  localparam int FLIT_TYPE_LSB = FLIT_W - 2;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(
    input logic [FLIT_W-1:0] f
  );
    return flit_type_e'(f[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO with fall-through head.
// Writes to a full FIFO and reads from an empty one are ignored.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int W     = FLIT_W,
  parameter int DEPTH = VC_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr;
  logic             rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr && !rd)
        count <= count + CNT_W'(1);
      else if (rd && !wr)
        count <= count - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Router input port buffer: per-VC FIFOs, round-robin head select,
// and one registered credit per dequeued flit back upstream.
module input_vc_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int NUM_VC = noc_pkg::NUM_VC,
  parameter int DEPTH  = noc_pkg::VC_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  output logic [VC_W-1:0]   out_vc,
  input  logic              out_pop,
  output logic              credit_valid,
  output logic [VC_W-1:0]   credit_vc,
  output logic [NUM_VC-1:0] vc_full,
  output logic [NUM_VC-1:0] vc_empty,
  output logic              overflow_err
);

  logic [NUM_VC-1:0]            push;
  logic [NUM_VC-1:0]            pop;
  logic [FLIT_W-1:0]            head [NUM_VC];
  logic [NUM_VC-1:0][CNT_W-1:0] cnt;
  logic [VC_W-1:0]              rr_ptr;
  logic [VC_W-1:0]              sel_vc;
  logic [VC_W-1:0]              nxt_ptr;
  logic                         any;
  logic                         do_pop;
  logic                         drop;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign push[g] = in_valid && (in_vc == VC_W'(g));
    assign pop[g]  = do_pop && (sel_vc == VC_W'(g));

    vc_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (in_flit),
      .dout  (head[g]),
      .full  (vc_full[g]),
      .empty (vc_empty[g]),
      .count (cnt[g])
    );
  end

  // Round-robin scan for the first non-empty VC starting at rr_ptr.
  always_comb begin
    logic [VC_W-1:0] idx;
    idx    = '0;
    sel_vc = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = VC_W'((int'(rr_ptr) + i) % NUM_VC);
      if (!any && !vc_empty[idx]) begin
        any    = 1'b1;
        sel_vc = idx;
      end
    end
  end

  assign out_valid = any;
  assign out_vc    = sel_vc;
  assign out_flit  = any ? head[sel_vc] : '0;
  assign do_pop    = out_pop && any;
  assign drop      = in_valid && (cnt[in_vc] == CNT_W'(DEPTH));
  assign nxt_ptr   = (sel_vc == VC_W'(NUM_VC - 1)) ?
                     '0 : sel_vc + VC_W'(1);

  // Arbiter pointer, credit return and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      overflow_err <= 1'b0;
    end else begin
      credit_valid <= do_pop;
      credit_vc    <= do_pop ? sel_vc : '0;
      if (do_pop) rr_ptr <= nxt_ptr;
      if (drop) overflow_err <= 1'b1;
    end
  end

endmodule
